// File: rtl/mmio_write_buffer.sv
// Store steering between the CPU, data RAM and an MMIO FIFO that drains to a slow peripheral bus.
// Optional WRBUF_DROP_CNT_EN adds a saturating dropped-store counter readable at offset 0xF8.
module mmio_write_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  input  logic [31:0] ram_rdata,
  output logic        ram_we,
  output logic        bus_valid,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_data,
  input  logic        bus_ready,
  output logic        overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [39:0]   mem_q [DEPTH];
  logic [39:0]   head;

  logic       hit, is_status, is_drop_reg, enq, deq, do_enq, drop, clr, empty, full;
  logic [7:0] off;

  assign hit         = (Mem_WrAddr[31:8] == BASE_ADDR[31:8]);
  assign off         = Mem_WrAddr[7:0];
  assign is_status   = hit && (off == 8'hFC);
  assign is_drop_reg = hit && (off == 8'hF8);

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthCnt);

  assign ram_we    = MemWrite && !hit;
  assign enq       = MemWrite && hit && !is_status && !is_drop_reg;
  assign bus_valid = !empty;
  assign deq       = bus_valid && bus_ready;
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign do_enq    = enq && (!full || deq);
  assign drop      = enq && full && !deq;
  assign clr       = MemWrite && is_status && Mem_WrData[0];

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (deq)    rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_enq) wr_ptr_d = wr_ptr_q + PW'(1);
    case ({do_enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop)     overflow_d = 1'b1;
    else if (clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; empty masking keeps stale entries off the bus.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= {off, Mem_WrData};
  end

  assign head     = mem_q[rd_ptr_q];
  assign bus_addr = empty ? 8'h00 : head[39:32];
  assign bus_data = empty ? 32'h0 : head[31:0];
  assign overflow = overflow_q;

`ifdef WRBUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (clr) begin
      drop_cnt_d = 16'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= 16'h0;
    else        drop_cnt_q <= drop_cnt_d;
  end
`endif

  always_comb begin
    ReadData = ram_rdata;
    if (is_status) begin
      ReadData = {overflow_q, 13'b0, full, empty, 16'(count_q)};
    end else if (is_drop_reg) begin
`ifdef WRBUF_DROP_CNT_EN
      ReadData = {16'b0, drop_cnt_q};
`else
      ReadData = 32'h0;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_write_buffer.sv
// Directed self-checking bench for mmio_write_buffer (DEPTH=4, BASE_ADDR=0x1000).
module tb_mmio_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Mem_WrAddr, Mem_WrData, ReadData, ram_rdata;
  logic        ram_we, bus_valid, bus_ready, overflow;
  logic [7:0]  bus_addr;
  logic [31:0] bus_data;

  int errors = 0;
  int checks = 0;

  mmio_write_buffer #(.DEPTH(4), .BASE_ADDR(32'h0000_1000)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .ReadData   (ReadData),
    .ram_rdata  (ram_rdata),
    .ram_we     (ram_we),
    .bus_valid  (bus_valid),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_ready  (bus_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite   = 1'b1;
    Mem_WrAddr = a;
    Mem_WrData = d;
    tick();
    MemWrite   = 1'b0;
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    Mem_WrAddr = 32'h0000_10FC;
    #1;
    check(tag, ReadData, exp);
  endtask

  task automatic check_head(input string tag, input logic v, input logic [7:0] a,
                            input logic [31:0] d);
    check({tag, "_valid"}, {31'b0, bus_valid}, {31'b0, v});
    check({tag, "_addr"}, {24'b0, bus_addr}, {24'b0, a});
    check({tag, "_data"}, bus_data, d);
  endtask

  initial begin
    reset      = 1'b0;
    MemWrite   = 1'b0;
    Mem_WrAddr = 32'h0;
    Mem_WrData = 32'h0;
    ram_rdata  = 32'h1234_5678;
    bus_ready  = 1'b0;
    repeat (2) tick();

    // Reset state
    check_head("rst", 1'b0, 8'h00, 32'h0);
    check("rst_ovf", {31'b0, overflow}, 32'h0);
    read_status("rst_status", 32'h0001_0000);
    reset = 1'b1;
    tick();

    // RAM passthrough
    MemWrite   = 1'b1;
    Mem_WrAddr = 32'h0000_0040;
    Mem_WrData = 32'hDEAD_BEEF;
    #1;
    check("pass_we", {31'b0, ram_we}, 32'h1);
    check("pass_rdata", ReadData, 32'h1234_5678);
    tick();
    MemWrite = 1'b0;
    check("pass_novalid", {31'b0, bus_valid}, 32'h0);
    read_status("pass_status", 32'h0001_0000);

    // Ordering, with first-entry latency
    MemWrite   = 1'b1;
    Mem_WrAddr = 32'h0000_1000;
    Mem_WrData = 32'h1;
    #1;
    check("win_we", {31'b0, ram_we}, 32'h0);
    check("nobypass_valid", {31'b0, bus_valid}, 32'h0);
    tick();
    MemWrite = 1'b0;
    check_head("lat", 1'b1, 8'h00, 32'h1);
    store(32'h0000_1004, 32'h2);
    store(32'h0000_1008, 32'h3);
    read_status("ord_status", 32'h0000_0003);
    bus_ready = 1'b1;
    #1;
    check_head("ord0", 1'b1, 8'h00, 32'h1);
    tick();
    check_head("ord1", 1'b1, 8'h04, 32'h2);
    tick();
    check_head("ord2", 1'b1, 8'h08, 32'h3);
    tick();
    check_head("ord_end", 1'b0, 8'h00, 32'h0);
    bus_ready = 1'b0;

    // Backpressure and overflow
    store(32'h0000_1010, 32'h10);
    store(32'h0000_1014, 32'h11);
    store(32'h0000_1018, 32'h12);
    store(32'h0000_101C, 32'h13);
    read_status("full_status", 32'h0002_0004);
    store(32'h0000_1020, 32'h14);
    read_status("ovf_status", 32'h8002_0004);
    check_head("ovf_head", 1'b1, 8'h10, 32'h10);
    tick();
    check_head("hold_head", 1'b1, 8'h10, 32'h10);

`ifdef WRBUF_DROP_CNT_EN
    Mem_WrAddr = 32'h0000_10F8;
    #1;
    check("dropcnt_pre", ReadData, 32'h1);
`endif

    // Clear
    store(32'h0000_10FC, 32'h1);
    read_status("clr_status", 32'h0002_0004);
    check_head("clr_head", 1'b1, 8'h10, 32'h10);
`ifdef WRBUF_DROP_CNT_EN
    Mem_WrAddr = 32'h0000_10F8;
    #1;
    check("dropcnt_post", ReadData, 32'h0);
`endif

    // Full with simultaneous enqueue and dequeue
    bus_ready = 1'b1;
    store(32'h0000_1030, 32'hAA);
    bus_ready = 1'b0;
    read_status("fulldeq_status", 32'h0002_0004);
    check("fulldeq_ovf", {31'b0, overflow}, 32'h0);
    check_head("fulldeq_head", 1'b1, 8'h14, 32'h11);
    bus_ready = 1'b1;
    tick();
    check_head("drain1", 1'b1, 8'h18, 32'h12);
    tick();
    check_head("drain2", 1'b1, 8'h1C, 32'h13);
    tick();
    check_head("drain3", 1'b1, 8'h30, 32'hAA);
    tick();
    check_head("drain_end", 1'b0, 8'h00, 32'h0);
    bus_ready = 1'b0;

    // Store to 0xF8 is ignored
    MemWrite   = 1'b1;
    Mem_WrAddr = 32'h0000_10F8;
    Mem_WrData = 32'h5555_5555;
    #1;
    check("f8_we", {31'b0, ram_we}, 32'h0);
    check("f8_read", ReadData, 32'h0);
    tick();
    MemWrite = 1'b0;
    read_status("f8_status", 32'h0001_0000);

    // Asynchronous reset mid-stream
    store(32'h0000_1040, 32'h77);
    store(32'h0000_1044, 32'h88);
    read_status("pre_rst_status", 32'h0000_0002);
    #2;
    reset = 1'b0;
    #1;
    check_head("async_rst", 1'b0, 8'h00, 32'h0);
    read_status("async_rst_status", 32'h0001_0000);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_valid", {31'b0, bus_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

endmodule
